// File: rtl/output_layer_argmax_pkg.sv
// Shared types and helpers for the output-layer argmax stage.
package output_layer_argmax_pkg;

   // Default activation width; matches the ROM word width of the ELM datapath.
   localparam int unsigned RomBitwidth = 8;

   typedef enum logic [1:0] {
      StCollect = 2'd0,
      StScan    = 2'd1
   } state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/output_layer_argmax_if.sv
// Neuron-output collection bus and classification result bundle.
interface output_layer_argmax_if #(
   parameter int unsigned NUM_NEURONS = 10,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned IDX_WIDTH   = 4
);
   logic [NUM_NEURONS*DATA_WIDTH-1:0] i_data;
   logic [NUM_NEURONS-1:0]            i_valid;
   logic                              o_busy;
   logic [IDX_WIDTH-1:0]              o_class;
   logic [DATA_WIDTH-1:0]             o_max;
   logic                              o_valid;
   logic                              o_overrun;

   modport master (
      output i_data, i_valid,
      input  o_busy, o_class, o_max, o_valid, o_overrun
   );

   modport slave (
      input  i_data, i_valid,
      output o_busy, o_class, o_max, o_valid, o_overrun
   );
endinterface

// File: rtl/output_layer_argmax_cmp.sv
// Strict greater-than compare, signed or unsigned by parameter.
module output_layer_argmax_cmp #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter bit          IS_SIGNED  = 1'b0
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  gt
);
   always_comb begin
      if (IS_SIGNED) gt = $signed(a) > $signed(b);
      else           gt = a > b;
   end
endmodule

// File: rtl/output_layer_argmax.sv
// Collects per-neuron activations, then serially scans them for the maximum and its index.
module output_layer_argmax
   import output_layer_argmax_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = 10,
   parameter int unsigned DATA_WIDTH  = RomBitwidth,
   parameter bit          IS_SIGNED   = 1'b0,
   parameter int unsigned IDX_WIDTH   = idx_width(NUM_NEURONS)
) (
   input logic                  clk,
   input logic                  rst,
   output_layer_argmax_if.slave bus
);

   localparam bit                   SingleNeuron = (NUM_NEURONS == 1);
   localparam logic [IDX_WIDTH-1:0] LastIdx      = IDX_WIDTH'(NUM_NEURONS - 1);

   state_e                 state_q, state_d;
   logic [NUM_NEURONS-1:0] seen_q, seen_d;
   logic [DATA_WIDTH-1:0]  buffer_q [NUM_NEURONS];
   logic [DATA_WIDTH-1:0]  buffer_d [NUM_NEURONS];
   logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  run_max_q, run_max_d;
   logic [IDX_WIDTH-1:0]   run_idx_q, run_idx_d;
   logic [IDX_WIDTH-1:0]   class_q, class_d;
   logic [DATA_WIDTH-1:0]  max_q, max_d;
   logic                   valid_q, valid_d;
   logic                   overrun_q, overrun_d;

   logic [DATA_WIDTH-1:0]  value0;
   logic [DATA_WIDTH-1:0]  cand;
   logic                   cand_gt;

   // Element 0 may arrive on the very edge that completes the collection.
   assign value0 = bus.i_valid[0] ? bus.i_data[DATA_WIDTH-1:0] : buffer_q[0];
   assign cand   = buffer_q[cnt_q];

   output_layer_argmax_cmp #(
      .DATA_WIDTH (DATA_WIDTH),
      .IS_SIGNED  (IS_SIGNED)
   ) u_cmp (
      .a  (cand),
      .b  (run_max_q),
      .gt (cand_gt)
   );

   always_comb begin
      state_d   = state_q;
      seen_d    = seen_q;
      buffer_d  = buffer_q;
      cnt_d     = cnt_q;
      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
      class_d   = class_q;
      max_d     = max_q;
      valid_d   = 1'b0;
      overrun_d = 1'b0;

      unique case (state_q)
         StCollect: begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
               if (bus.i_valid[k]) begin
                  buffer_d[k] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
                  seen_d[k]   = 1'b1;
               end
            end
            overrun_d = |(bus.i_valid & seen_q);
            if (&(seen_q | bus.i_valid)) begin
               seen_d = '0;
               if (SingleNeuron) begin
                  class_d = '0;
                  max_d   = value0;
                  valid_d = 1'b1;
               end else begin
                  run_max_d = value0;
                  run_idx_d = '0;
                  cnt_d     = IDX_WIDTH'(1);
                  state_d   = StScan;
               end
            end
         end
         StScan: begin
            // Inputs are not captured while scanning; flag the loss.
            overrun_d = |bus.i_valid;
            if (cand_gt) begin
               run_max_d = cand;
               run_idx_d = cnt_q;
            end
            if (cnt_q == LastIdx) begin
               class_d = cand_gt ? cnt_q : run_idx_q;
               max_d   = cand_gt ? cand : run_max_q;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = StCollect;
            end else begin
               cnt_d = cnt_q + IDX_WIDTH'(1);
            end
         end
         default: state_d = StCollect;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StCollect;
         seen_q    <= '0;
         buffer_q  <= '{default: '0};
         cnt_q     <= '0;
         run_max_q <= '0;
         run_idx_q <= '0;
         class_q   <= '0;
         max_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         seen_q    <= seen_d;
         buffer_q  <= buffer_d;
         cnt_q     <= cnt_d;
         run_max_q <= run_max_d;
         run_idx_q <= run_idx_d;
         class_q   <= class_d;
         max_q     <= max_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.o_busy    = (state_q == StScan);
   assign bus.o_class   = class_q;
   assign bus.o_max     = max_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_overrun = overrun_q;

endmodule
